// File: rtl/mcu_lsu_defs.sv
// Shared definitions for the load/store unit: FSM encoding, byte-enable
// constants and the byte-lane enable helper.
package mcu_lsu_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } lsu_state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] PC_REG  = 4'd15;

    function automatic logic [3:0] lane_be(input logic [1:0] addr_lo, input logic is_byte);
        logic [3:0] be;
        if (is_byte) begin
            be = 4'b0001 << addr_lo;
        end else begin
            be = BE_WORD;
        end
        return be;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: byte enables, replicated store data and
// zero-extended load data for the selected lane.
module lsu_byte_lane
    import mcu_lsu_defs::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic        i_is_byte,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [7:0] w_rd_byte;

    // Lane steering for store enables/data and load byte selection
    always_comb begin
        o_be = lane_be(i_addr_lo, i_is_byte);
        case (i_addr_lo)
            2'd0:    w_rd_byte = i_mem_rdata[7:0];
            2'd1:    w_rd_byte = i_mem_rdata[15:8];
            2'd2:    w_rd_byte = i_mem_rdata[23:16];
            2'd3:    w_rd_byte = i_mem_rdata[31:24];
            default: w_rd_byte = 8'd0;
        endcase
        if (i_is_byte) begin
            o_wdata = {4{i_store_data[7:0]}};
            o_ldata = {24'd0, w_rd_byte};
        end else begin
            o_wdata = i_store_data;
            o_ldata = i_mem_rdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: issues one req/ack memory transaction per op
// and returns load data to the register file or the PC-load port.
module load_store_unit
    import mcu_lsu_defs::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TMO_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_byte,
    input  logic [3:0]  rd,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        rf_we,
    output logic [3:0]  rf_a3,
    output logic [31:0] rf_wd3,
    output logic        pc_ld,
    output logic [31:0] pc_val,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    lsu_state_e       r_state;
    lsu_state_e       w_state_nx;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] w_tmo_nx;

    logic        r_is_load;
    logic        r_is_byte;
    logic [3:0]  r_rd;
    logic [1:0]  r_addr_lo;

    logic        r_busy, r_done, r_err, r_rf_we, r_pc_ld, r_mem_req, r_mem_we;
    logic [3:0]  r_rf_a3, r_mem_be;
    logic [31:0] r_rf_wd3, r_pc_val, r_mem_addr, r_mem_wdata;

    logic        w_busy_nx, w_done_nx, w_err_nx, w_rf_we_nx, w_pc_ld_nx;
    logic        w_req_nx, w_we_nx;
    logic        w_accept, w_issue, w_capture;

    logic [1:0]  w_lane_addr_lo;
    logic        w_lane_is_byte;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;

    // During the access the lane follows the latched op; otherwise the live issue inputs
    always_comb begin
        if (r_state == ST_ACCESS) begin
            w_lane_addr_lo = r_addr_lo;
            w_lane_is_byte = r_is_byte;
        end else begin
            w_lane_addr_lo = addr[1:0];
            w_lane_is_byte = is_byte;
        end
    end

    lsu_byte_lane u_lane (
        .i_addr_lo    (w_lane_addr_lo),
        .i_is_byte    (w_lane_is_byte),
        .i_store_data (store_data),
        .i_mem_rdata  (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_ldata      (w_ldata)
    );

    // Next-state and next-output logic; WB accepts a new op so back-to-back issue works
    always_comb begin
        w_state_nx = r_state;
        w_tmo_nx   = r_tmo_cnt;
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        w_rf_we_nx = 1'b0;
        w_pc_ld_nx = 1'b0;
        w_req_nx   = r_mem_req;
        w_we_nx    = r_mem_we;
        w_accept   = 1'b0;
        w_issue    = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE, ST_WB: begin
                w_state_nx = ST_IDLE;
                w_req_nx   = 1'b0;
                w_we_nx    = 1'b0;
                if (start) begin
                    w_accept = 1'b1;
                    if (!is_byte && (addr[1:0] != 2'b00)) begin
                        w_done_nx = 1'b1;
                        w_err_nx  = 1'b1;
                    end else begin
                        w_issue    = 1'b1;
                        w_state_nx = ST_ACCESS;
                        w_busy_nx  = 1'b1;
                        w_req_nx   = 1'b1;
                        w_we_nx    = !is_load;
                        w_tmo_nx   = {TMO_W{1'b0}};
                    end
                end else begin
                    w_accept = 1'b0;
                end
            end
            ST_ACCESS: begin
                w_busy_nx = 1'b1;
                if (mem_ack) begin
                    w_req_nx  = 1'b0;
                    w_we_nx   = 1'b0;
                    w_done_nx = 1'b1;
                    if (r_is_load) begin
                        w_capture  = 1'b1;
                        w_state_nx = ST_WB;
                        w_rf_we_nx = (r_rd != PC_REG);
                        w_pc_ld_nx = (r_rd == PC_REG);
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_req_nx   = 1'b0;
                    w_we_nx    = 1'b0;
                    w_done_nx  = 1'b1;
                    w_err_nx   = 1'b1;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_tmo_nx = r_tmo_cnt + TMO_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_req_nx   = 1'b0;
                w_we_nx    = 1'b0;
            end
        endcase
    end

    // FSM state and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else begin
            r_state   <= w_state_nx;
            r_tmo_cnt <= w_tmo_nx;
        end
    end

    // Op latch, memory interface and writeback output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_load   <= 1'b0;
            r_is_byte   <= 1'b0;
            r_rd        <= 4'd0;
            r_addr_lo   <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rf_we     <= 1'b0;
            r_pc_ld     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rf_a3     <= 4'd0;
            r_rf_wd3    <= 32'd0;
            r_pc_val    <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
        end else begin
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_err     <= w_err_nx;
            r_rf_we   <= w_rf_we_nx;
            r_pc_ld   <= w_pc_ld_nx;
            r_mem_req <= w_req_nx;
            r_mem_we  <= w_we_nx;
            if (w_accept) begin
                r_is_load <= is_load;
                r_is_byte <= is_byte;
                r_rd      <= rd;
                r_addr_lo <= addr[1:0];
            end
            if (w_issue) begin
                r_mem_addr  <= {addr[31:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
            end
            if (w_capture && (r_rd != PC_REG)) begin
                r_rf_a3  <= r_rd;
                r_rf_wd3 <= w_ldata;
            end
            if (w_capture && (r_rd == PC_REG)) begin
                r_pc_val <= w_ldata;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rf_we     = r_rf_we;
    assign rf_a3     = r_rf_a3;
    assign rf_wd3    = r_rf_wd3;
    assign pc_ld     = r_pc_ld;
    assign pc_val    = r_pc_val;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against a behavioural
// model of each memory op computed from address/size rules.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_load, is_byte;
    logic [3:0]  rd;
    logic [31:0] addr, store_data;
    logic        busy, done, err, rf_we, pc_ld, mem_req, mem_we, mem_ack;
    logic [3:0]  rf_a3, mem_be;
    logic [31:0] rf_wd3, pc_val, mem_addr, mem_wdata, mem_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    load_store_unit #(.TIMEOUT(TIMEOUT), .TMO_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_load    (is_load),
        .is_byte    (is_byte),
        .rd         (rd),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rf_we      (rf_we),
        .rf_a3      (rf_a3),
        .rf_wd3     (rf_wd3),
        .pc_ld      (pc_ld),
        .pc_val     (pc_val),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete op. ack_after = number of req cycles before ack (>= TIMEOUT means never).
    task automatic do_op(input bit ld, input bit byt, input logic [3:0] rdx,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdat, input int ack_after, input bit poke);
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_ld, e_addr;
        bit          mis, acked, wr_rf, wr_pc;
        mis    = !byt && (a % 4 != 0);
        e_addr = a - (a % 4);
        e_be   = byt ? 4'(1 << (a % 4)) : 4'b1111;
        e_wd   = byt ? (sd & 32'hFF) * 32'h0101_0101 : sd;
        e_ld   = byt ? ((rdat >> (8 * (a % 4))) & 32'hFF) : rdat;

        start = 1'b1; is_load = ld; is_byte = byt; rd = rdx; addr = a; store_data = sd;
        mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (mis) begin
            chk1("mis_done", done, 1'b1);
            chk1("mis_err", err, 1'b1);
            chk1("mis_busy", busy, 1'b0);
            chk1("mis_req", mem_req, 1'b0);
            @(negedge clk);
            chk1("mis_done_pulse", done, 1'b0);
            chk1("mis_err_pulse", err, 1'b0);
            chk1("mis_req_after", mem_req, 1'b0);
            return;
        end
        acked = 1'b0;
        for (int k = 0; k < TIMEOUT && !acked; k++) begin
            chk1("req", mem_req, 1'b1);
            chk1("busy", busy, 1'b1);
            chk1("no_done", done, 1'b0);
            chk1("we", mem_we, !ld);
            chk32("maddr", mem_addr, e_addr);
            chk32("mbe", 32'(mem_be), 32'(e_be));
            if (!ld) chk32("mwdata", mem_wdata, e_wd);
            acked     = (k == ack_after);
            mem_ack   = acked;
            mem_rdata = acked ? rdat : $urandom;
            if (poke && !acked) begin
                start = 1'b1; addr = $urandom; is_byte = $urandom_range(0, 1);
                is_load = $urandom_range(0, 1); store_data = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        wr_rf = acked && ld && (rdx != 4'd15);
        wr_pc = acked && ld && (rdx == 4'd15);
        chk1("done", done, 1'b1);
        chk1("err", err, !acked);
        chk1("req_drop", mem_req, 1'b0);
        chk1("busy_done", busy, 1'b1);
        chk1("rf_we", rf_we, wr_rf);
        chk1("pc_ld", pc_ld, wr_pc);
        if (wr_rf) begin
            chk32("rf_a3", 32'(rf_a3), 32'(rdx));
            chk32("rf_wd3", rf_wd3, e_ld);
        end
        if (wr_pc) chk32("pc_val", pc_val, e_ld);
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("done_pulse", done, 1'b0);
        chk1("err_pulse", err, 1'b0);
        chk1("busy_clear", busy, 1'b0);
        chk1("rf_we_pulse", rf_we, 1'b0);
        chk1("pc_ld_pulse", pc_ld, 1'b0);
        chk1("idle_req", mem_req, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        bit          rl, rb;
        int          rk;
        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_byte = 1'b0; rd = 4'd0;
        addr = 32'd0; store_data = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_rf_we", rf_we, 1'b0);
        chk1("rst_pc_ld", pc_ld, 1'b0);
        chk1("rst_req", mem_req, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk32("rst_a3", 32'(rf_a3), 32'd0);
        chk32("rst_wd3", rf_wd3, 32'd0);
        chk32("rst_pc_val", pc_val, 32'd0);
        chk32("rst_maddr", mem_addr, 32'd0);
        chk32("rst_mwdata", mem_wdata, 32'd0);
        chk32("rst_mbe", 32'(mem_be), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1'b1, 1'b0, 4'd3,  32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 0,   1'b0);
        do_op(1'b0, 1'b1, 4'd7,  32'h0000_0203, 32'h0000_00A5, 32'h0,         3,   1'b1);
        do_op(1'b1, 1'b1, 4'd5,  32'h0000_0302, 32'h0,          32'h11C2_3344, 1,   1'b0);
        do_op(1'b1, 1'b0, 4'd15, 32'h0000_0040, 32'h0,          32'h0000_1234, 0,   1'b0);
        do_op(1'b1, 1'b0, 4'd2,  32'h0000_0101, 32'h0,          32'h0,         0,   1'b0);
        do_op(1'b0, 1'b0, 4'd1,  32'h0000_0500, 32'h1234_5678, 32'h0,         99,  1'b0);
        do_op(1'b1, 1'b0, 4'd4,  32'h0000_0600, 32'h0,          32'h0,         15,  1'b0);

        // Reset asserted in the middle of an access
        start = 1'b1; is_load = 1'b1; is_byte = 1'b0; rd = 4'd6; addr = 32'h0000_0700;
        @(negedge clk);
        start = 1'b0;
        chk1("rstm_req_before", mem_req, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("rstm_req_drop", mem_req, 1'b0);
        chk1("rstm_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("rstm_no_done", done, 1'b0);
            chk1("rstm_no_rf_we", rf_we, 1'b0);
            chk1("rstm_no_req", mem_req, 1'b0);
        end
        mem_ack = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rl = $urandom_range(0, 1);
            rb = $urandom_range(0, 1);
            if (!rb && $urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            rk = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 4);
            do_op(rl, rb, 4'($urandom_range(0, 15)), ra, $urandom, $urandom, rk,
                  $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
